dmem_lsu: RTL and testbench

//  Load/store unit and data RAM directly downstream of the cpu core.

---
 rtl/dmem_lsu.sv | 149 ++++++++++++++
 tb/tb_dmem_lsu.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// Load/store unit with a word-organised data RAM: lane-enabled byte/half/word stores,
// registered loads with sign/zero extension, and error flagging for bad requests.
module dmem_lsu #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             store,
    input  logic             load,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] address,
    input  logic [WIDTH-1:0] d,
    output logic             req_ready,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rdata,
    output logic             mem_err
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t               state, state_next;
    logic [WIDTH-1:0]     ram [DEPTH];
    logic [ADDR_BITS-1:0] idx;
    logic                 accept;
    logic                 f3_ok;
    logic                 misaligned;
    logic                 req_err;
    logic                 wr_en;
    logic [3:0]           be;
    logic [WIDTH-1:0]     wdata;
    logic [WIDTH-1:0]     rd_word_p0;
    logic [2:0]           f3_p0;
    logic [1:0]           off_p0;
    logic                 vld_p0;
    logic                 err_p0;
    logic                 unused_addr_hi;

    // Selects the addressed byte/half from the read word and extends it to WIDTH.
    function automatic logic [WIDTH-1:0] load_extend(input logic [WIDTH-1:0] word,
                                                     input logic [2:0]       f3,
                                                     input logic [1:0]       off);
        logic [WIDTH-1:0]   sh_b;
        logic [WIDTH-1:0]   sh_h;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [WIDTH-1:0]   res;
        sh_b = word >> {off, 3'b000};
        sh_h = word >> {off[1], 4'b0000};
        b    = $signed(sh_b[7:0]);
        h    = $signed(sh_h[15:0]);
        res  = '0;
        case (f3)
            3'b000:  res = {{(WIDTH-8){b[7]}}, b};
            3'b001:  res = {{(WIDTH-16){h[15]}}, h};
            3'b010:  res = word;
            3'b100:  res = {{(WIDTH-8){1'b0}}, b};
            3'b101:  res = {{(WIDTH-16){1'b0}}, h};
            default: res = '0;
        endcase
        return res;
    endfunction

    assign idx            = address[ADDR_BITS+1:2];
    assign unused_addr_hi = ^address[WIDTH-1:ADDR_BITS+2];
    assign req_ready      = (state == IDLE);
    assign accept         = (load | store) & req_ready & ~rst;

    always_comb begin
        f3_ok      = 1'b0;
        misaligned = 1'b0;
        be         = 4'b0000;
        wdata      = d;
        case (funct3)
            3'b000: begin
                f3_ok = 1'b1;
                be    = 4'b0001 << address[1:0];
                wdata = {4{d[7:0]}};
            end
            3'b001: begin
                f3_ok      = 1'b1;
                misaligned = address[0];
                be         = address[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{d[15:0]}};
            end
            3'b010: begin
                f3_ok      = 1'b1;
                misaligned = |address[1:0];
                be         = 4'b1111;
            end
            // Unsigned variants exist only for loads.
            3'b100, 3'b101: begin
                f3_ok      = load;
                misaligned = funct3[0] & address[0];
            end
            default: ;
        endcase
    end

    assign req_err = (load & store) | ~f3_ok | misaligned;
    assign wr_en   = accept & store & ~req_err;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && load) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Stage p0: control registers (reset) for the response cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            err_p0 <= 1'b0;
        end else begin
            state  <= state_next;
            err_p0 <= accept & req_err;
        end
    end

    // Stage p0: RAM write and synchronous read (data path, no reset)
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && be[i]) ram[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (accept && load) begin
            rd_word_p0 <= ram[idx];
            f3_p0      <= funct3;
            off_p0     <= address[1:0];
        end
    end

    // Output: extension of the registered word during the response cycle
    assign vld_p0    = (state == RESP);
    assign rsp_valid = vld_p0;
    assign mem_err   = err_p0;
    assign rdata     = (vld_p0 && !err_p0) ? load_extend(rd_word_p0, f3_p0, off_p0) : '0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed vector table, reset corner sequences, and random
// traffic against a byte-addressed memory model.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        store;
    logic        load;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] d;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        mem_err;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [4096];

    dmem_lsu #(.WIDTH(32), .ADDR_BITS(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .store    (store),
        .load     (load),
        .funct3   (funct3),
        .address  (address),
        .d        (d),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rdata    (rdata),
        .mem_err  (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        ld;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] dd;
        logic        ev;
        logic [31:0] erd;
        logic        ee;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", nm, got, exp);
        end
    endtask

    // Reference: byte-addressed memory of 4096 bytes (1024 words wrap), extension by arithmetic.
    function automatic void model(input logic st, input logic ld, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] dd,
                                  output logic ev, output logic ee, output logic [31:0] erd);
        int     sz = 1;
        bit     sgn = 0;
        int     base;
        longint v = 0;
        ev = ld; ee = 0; erd = '0;
        if (!st && !ld) begin ev = 0; return; end
        if (st && ld) ee = 1;
        if (ld) begin
            case (f3)
                3'd0: begin sz = 1; sgn = 1; end
                3'd1: begin sz = 2; sgn = 1; end
                3'd2: sz = 4;
                3'd4: sz = 1;
                3'd5: sz = 2;
                default: ee = 1;
            endcase
        end else begin
            case (f3)
                3'd0: sz = 1;
                3'd1: sz = 2;
                3'd2: sz = 4;
                default: ee = 1;
            endcase
        end
        if ((a % sz) != 0) ee = 1;
        if (ee) return;
        base = int'(a % 4096);
        if (st) begin
            for (int k = 0; k < sz; k++) mem[base + k] = dd[8*k +: 8];
        end else begin
            for (int k = 0; k < sz; k++) v += longint'(mem[base + k]) << (8 * k);
            if (sgn && v >= (longint'(1) << (8 * sz - 1))) v -= (longint'(1) << (8 * sz));
            erd = v[31:0];
        end
    endfunction

    // Drives one request, checks the cycle after acceptance, and for loads also the return to idle.
    task automatic run_op(input string nm, input logic st, input logic ld, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] dd,
                          input logic use_tbl, input logic tv, input logic [31:0] trd, input logic te);
        logic        ev, ee;
        logic [31:0] erd;
        model(st, ld, f3, a, dd, ev, ee, erd);
        if (use_tbl) begin ev = tv; ee = te; erd = trd; end
        @(negedge clk);
        store = st; load = ld; funct3 = f3; address = a; d = dd;
        @(posedge clk);
        #1;
        store = 0; load = 0;
        chk({nm, " rsp_valid"}, 32'(rsp_valid), 32'(ev));
        chk({nm, " mem_err"}, 32'(mem_err), 32'(ee));
        chk({nm, " req_ready"}, 32'(req_ready), 32'(!ev));
        if (ev) begin
            chk({nm, " rdata"}, rdata, erd);
            @(posedge clk);
            #1;
            chk({nm, " rsp_end"}, {30'd0, rsp_valid, mem_err}, 32'd0);
        end
    endtask

    vec_t vt[$];

    initial begin
        rst = 1; store = 0; load = 0; funct3 = 0; address = 0; d = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rdata", rdata, 32'd0);
        chk("reset mem_err", 32'(mem_err), 32'd0);
        @(negedge clk);
        rst = 0;

        //       st ld f3    addr          d              ev  rdata          err
        vt.push_back('{1, 0, 3'd2, 32'h4,    32'h0000F7FF, 0, 32'h0,        0});
        vt.push_back('{0, 1, 3'd2, 32'h4,    32'h0,        1, 32'h0000F7FF, 0});
        vt.push_back('{1, 0, 3'd2, 32'h8,    32'h0,        0, 32'h0,        0});
        vt.push_back('{1, 0, 3'd0, 32'h9,    32'h000000AB, 0, 32'h0,        0});
        vt.push_back('{0, 1, 3'd0, 32'h9,    32'h0,        1, 32'hFFFFFFAB, 0});
        vt.push_back('{0, 1, 3'd4, 32'h9,    32'h0,        1, 32'h000000AB, 0});
        vt.push_back('{0, 1, 3'd2, 32'h8,    32'h0,        1, 32'h0000AB00, 0});
        vt.push_back('{1, 0, 3'd1, 32'h6,    32'h12348001, 0, 32'h0,        0});
        vt.push_back('{0, 1, 3'd1, 32'h6,    32'h0,        1, 32'hFFFF8001, 0});
        vt.push_back('{0, 1, 3'd5, 32'h6,    32'h0,        1, 32'h00008001, 0});
        vt.push_back('{0, 1, 3'd2, 32'h4,    32'h0,        1, 32'h8001F7FF, 0});
        vt.push_back('{1, 0, 3'd2, 32'h0,    32'h11223344, 0, 32'h0,        0});
        vt.push_back('{1, 0, 3'd2, 32'h2,    32'hDEADBEEF, 0, 32'h0,        1});
        vt.push_back('{0, 1, 3'd2, 32'h0,    32'h0,        1, 32'h11223344, 0});
        vt.push_back('{0, 1, 3'd1, 32'h3,    32'h0,        1, 32'h0,        1});
        vt.push_back('{1, 0, 3'd2, 32'h1004, 32'hCAFEF00D, 0, 32'h0,        0});
        vt.push_back('{0, 1, 3'd2, 32'h4,    32'h0,        1, 32'hCAFEF00D, 0});
        vt.push_back('{0, 1, 3'd3, 32'h0,    32'h0,        1, 32'h0,        1});
        vt.push_back('{1, 0, 3'd4, 32'h0,    32'h000000FF, 0, 32'h0,        1});
        vt.push_back('{1, 1, 3'd2, 32'h0,    32'h55555555, 1, 32'h0,        1});
        vt.push_back('{0, 1, 3'd2, 32'h0,    32'h0,        1, 32'h11223344, 0});
        vt.push_back('{0, 1, 3'd0, 32'h3,    32'h0,        1, 32'h00000011, 0});

        foreach (vt[i])
            run_op($sformatf("vec%0d", i), vt[i].st, vt[i].ld, vt[i].f3, vt[i].a, vt[i].dd,
                   1'b1, vt[i].ev, vt[i].erd, vt[i].ee);

        // Reset concurrent with a load request: nothing accepted, no response.
        @(negedge clk);
        rst = 1; load = 1; funct3 = 3'd2; address = 32'h4;
        @(posedge clk);
        #1;
        load = 0;
        chk("rst+load rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst+load req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 0;

        // Reset asserted during the response cycle returns the FSM to idle with no further response.
        @(negedge clk);
        load = 1; funct3 = 3'd2; address = 32'h4;
        @(posedge clk);
        #1;
        load = 0;
        chk("rsp cycle rsp_valid", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
        chk("rst in resp rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst in resp req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 0;

        // Random phase: seed a 64-byte window, then mixed traffic with aliasing high address bits.
        for (int w = 0; w < 16; w++)
            run_op("init", 1'b1, 1'b0, 3'd2, 32'(w * 4), $urandom, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int n = 0; n < 400; n++) begin
            int          r;
            logic        st, ld;
            logic [2:0]  f3;
            logic [31:0] a;
            r  = $urandom_range(0, 99);
            st = (r < 40) || (r >= 95);
            ld = (r >= 40 && r < 90) || (r >= 95);
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'($urandom_range(0, 5));
            a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            run_op($sformatf("rnd%0d", n), st, ld, f3, a, $urandom, 1'b0, 1'b0, 32'h0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
